// File: rtl/dac_seg_encoder.sv
// Segmented DAC code encoder: splits a 13-bit code into binary LSBs and a thermometer MSB field,
// and sequences the driver cell through power-up, run, ramp-test and graceful power-down.
module dac_seg_encoder #(
    parameter int BIN_W       = 8,
    parameter int THERM_W     = 17,
    parameter int MSB_W       = 5,
    parameter int WAKE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pdb,
    input  logic [MSB_W+BIN_W-1:0] code_in,
    input  logic                   code_valid,
    output logic                   code_ready,
    input  logic                   test_mode,
    input  logic [BIN_W-1:0]       ramp_step,
    output logic [BIN_W-1:0]       datain,
    output logic [BIN_W-1:0]       datainb,
    output logic [THERM_W-1:0]     datatherm,
    output logic [THERM_W-1:0]     datathermb,
    output logic                   pdb_out,
    output logic                   ovf,
    output logic                   busy
);

    localparam int CODE_W = MSB_W + BIN_W;
    localparam int WCNT_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WAKE_LOAD = WCNT_W'(WAKE_CYCLES - 1);
    localparam logic [MSB_W-1:0]  THERM_MAX = MSB_W'(THERM_W);
    // Ramp wraps one past the largest legal code (all segments on, LSBs all ones).
    localparam logic [CODE_W-1:0] RAMP_MOD  = CODE_W'((THERM_W + 1) << BIN_W);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_RUN  = 2'd2,
        ST_PARK = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wake_cnt_q, wake_cnt_d;
    logic [CODE_W-1:0]   acc_q, acc_d;
    logic [CODE_W-1:0]   acc_sum;
    logic                s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0]   s1_code_q, s1_code_d;
    logic [BIN_W-1:0]    datain_q, datain_d;
    logic [BIN_W-1:0]    datainb_q;
    logic [THERM_W-1:0]  therm_q, therm_d;
    logic [THERM_W-1:0]  thermb_q;
    logic                ovf_q, ovf_d;

    logic                run_live;
    logic                accept;
    logic                ramp_take;
    logic [MSB_W-1:0]    s1_msb;
    logic [BIN_W-1:0]    s1_lsb;
    logic                clamp;
    logic [THERM_W-1:0]  therm_enc;
    logic [BIN_W-1:0]    bin_enc;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (pdb) state_d = ST_WAKE;
            end
            ST_WAKE: begin
                if (!pdb) begin
                    state_d = ST_OFF;
                end else if (wake_cnt_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!pdb) state_d = ST_PARK;
            end
            ST_PARK: begin
                // Leave only once the zero thermometer count is already on the outputs.
                if (therm_q == '0) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the state register
    // ------------------------------------------------------------------
    always_comb begin
        code_ready = 1'b0;
        busy       = 1'b0;
        pdb_out    = 1'b0;
        case (state_q)
            ST_OFF: begin
                pdb_out = 1'b0;
            end
            ST_WAKE: begin
                pdb_out = 1'b1;
                busy    = 1'b1;
            end
            ST_RUN: begin
                pdb_out = 1'b1;
                // Drops in the same cycle pdb falls so no code slips in before parking.
                code_ready = ~test_mode & pdb;
            end
            ST_PARK: begin
                pdb_out = 1'b1;
                busy    = 1'b1;
            end
            default: begin
                pdb_out = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Wake counter
    // ------------------------------------------------------------------
    always_comb begin
        wake_cnt_d = wake_cnt_q;
        if (state_q == ST_OFF && pdb) begin
            wake_cnt_d = WAKE_LOAD;
        end else if (state_q == ST_WAKE && wake_cnt_q != '0) begin
            wake_cnt_d = wake_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wake_cnt_q <= '0;
        end else begin
            wake_cnt_q <= wake_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture an accepted code or the ramp accumulator
    // ------------------------------------------------------------------
    assign run_live  = (state_q == ST_RUN) && pdb;
    assign accept    = code_valid && code_ready;
    assign ramp_take = run_live && test_mode;
    assign acc_sum   = acc_q + CODE_W'(ramp_step);

    always_comb begin
        acc_d      = acc_q;
        s1_valid_d = 1'b0;
        s1_code_d  = s1_code_q;
        if (ramp_take) begin
            s1_valid_d = 1'b1;
            s1_code_d  = acc_q;
            acc_d      = (acc_sum >= RAMP_MOD) ? (acc_sum - RAMP_MOD) : acc_sum;
        end else if (accept) begin
            s1_valid_d = 1'b1;
            s1_code_d  = code_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
        end else begin
            acc_q      <= acc_d;
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 encoder: thermometer from the MSB field, saturating on overrange
    // ------------------------------------------------------------------
    assign s1_msb = s1_code_q[CODE_W-1:BIN_W];
    assign s1_lsb = s1_code_q[BIN_W-1:0];
    assign clamp  = (s1_msb > THERM_MAX);

    genvar gi;
    generate
        for (gi = 0; gi < THERM_W; gi++) begin : g_therm
            assign therm_enc[gi] = (s1_msb > MSB_W'(gi));
        end
        for (gi = 0; gi < BIN_W; gi++) begin : g_bin
            assign bin_enc[gi] = s1_lsb[gi] | clamp;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register next-state
    // ------------------------------------------------------------------
    always_comb begin
        datain_d = datain_q;
        therm_d  = therm_q;
        ovf_d    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!pdb) begin
                    // First parking cycle: binary off, thermometer held; in-flight code dropped.
                    datain_d = '0;
                end else if (s1_valid_q) begin
                    datain_d = bin_enc;
                    therm_d  = therm_enc;
                    ovf_d    = clamp;
                end
            end
            ST_PARK: begin
                // A contiguous thermometer shifted right loses exactly one segment.
                datain_d = '0;
                therm_d  = therm_q >> 1;
            end
            default: begin
                datain_d = '0;
                therm_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            datain_q  <= '0;
            datainb_q <= '1;
            therm_q   <= '0;
            thermb_q  <= '1;
            ovf_q     <= 1'b0;
        end else begin
            datain_q  <= datain_d;
            datainb_q <= ~datain_d;
            therm_q   <= therm_d;
            thermb_q  <= ~therm_d;
            ovf_q     <= ovf_d;
        end
    end

    assign datain     = datain_q;
    assign datainb    = datainb_q;
    assign datatherm  = therm_q;
    assign datathermb = thermb_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_dac_seg_encoder.sv
// Self-checking bench for dac_seg_encoder: vector table, random codes against an arithmetic
// encoding model, ramp wrap, wake/park sequencing and reset corner cases.
module tb_dac_seg_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        pdb;
    logic [12:0] code_in;
    logic        code_valid;
    logic        code_ready;
    logic        test_mode;
    logic [7:0]  ramp_step;
    logic [7:0]  datain, datainb;
    logic [16:0] datatherm, datathermb;
    logic        pdb_out, ovf, busy;

    int n_tests = 0;
    int n_fail  = 0;

    dac_seg_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .pdb        (pdb),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .test_mode  (test_mode),
        .ramp_step  (ramp_step),
        .datain     (datain),
        .datainb    (datainb),
        .datatherm  (datatherm),
        .datathermb (datathermb),
        .pdb_out    (pdb_out),
        .ovf        (ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] code;
        logic [7:0]  bin;
        logic [16:0] therm;
        logic        ovf;
    } vec_t;

    vec_t vtab[9];

    // Reference model state
    logic [7:0]  m_bin;
    logic [16:0] m_therm;
    logic        m_ovf;
    logic        pend_v;
    int          pend_c;
    int          acc_m;
    int          prev_obs;
    bit          saw_wrap;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Complementary buses must never disagree, sampled mid-cycle.
    always @(negedge clk) begin
        chk("compl_bin", {24'd0, datainb}, {24'd0, ~datain});
        chk("compl_therm", {15'd0, datathermb}, {15'd0, ~datatherm});
    end

    task automatic enc(input int code, output logic [7:0] b, output logic [16:0] t, output logic o);
        int m;
        m = code / 256;
        if (m > 17) begin
            t = 17'h1FFFF;
            b = 8'hFF;
            o = 1'b1;
        end else begin
            t = 17'((1 << m) - 1);
            b = 8'(code % 256);
            o = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [7:0] b, input logic [16:0] t, input logic o);
        chk({nm, "_bin"}, {24'd0, datain}, {24'd0, b});
        chk({nm, "_therm"}, {15'd0, datatherm}, {15'd0, t});
        chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, o});
    endtask

    task automatic wake_up(input string nm);
        int n;
        pdb = 1'b1;
        step();
        chk({nm, "_pdbout"}, {31'd0, pdb_out}, 32'd1);
        n = 0;
        while (!code_ready && n < 40) begin
            step();
            n++;
        end
        chk({nm, "_wake_len"}, n, 32'd16);
    endtask

    // One RUN cycle: the model says a code entering now is visible after the following edge.
    task automatic run_cycle(input logic v, input logic [12:0] c, input logic tm, input logic [7:0] st);
        logic ent_v;
        int   ent_c;
        int   obs;
        code_valid = v;
        code_in    = c;
        test_mode  = tm;
        ramp_step  = st;
        #1;
        chk("ready", {31'd0, code_ready}, {31'd0, ~tm});
        ent_v = tm | v;
        ent_c = int'(c);
        if (tm) begin
            ent_c = acc_m;
            acc_m = (acc_m + int'(st)) % 4608;
        end
        step();
        if (pend_v) enc(pend_c, m_bin, m_therm, m_ovf);
        else        m_ovf = 1'b0;
        chk_out("run", m_bin, m_therm, m_ovf);
        obs = $countones(datatherm) * 256 + int'(datain);
        if (prev_obs == 4592 && obs == 0) saw_wrap = 1'b1;
        prev_obs   = obs;
        pend_v     = ent_v;
        pend_c     = ent_c;
        code_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vtab[0] = '{13'h0A5C, 8'h5C, 17'h003FF, 1'b0};
        vtab[1] = '{13'h0000, 8'h00, 17'h00000, 1'b0};
        vtab[2] = '{13'h1100, 8'h00, 17'h1FFFF, 1'b0};
        vtab[3] = '{13'h01FF, 8'hFF, 17'h00001, 1'b0};
        vtab[4] = '{13'h1412, 8'hFF, 17'h1FFFF, 1'b1};
        vtab[5] = '{13'h0780, 8'h80, 17'h0007F, 1'b0};
        vtab[6] = '{13'h1FFF, 8'hFF, 17'h1FFFF, 1'b1};
        vtab[7] = '{13'h10AA, 8'hAA, 17'h0FFFF, 1'b0};
        vtab[8] = '{13'h1200, 8'hFF, 17'h1FFFF, 1'b1};

        rst = 1'b1; pdb = 1'b0; code_in = '0; code_valid = 1'b0;
        test_mode = 1'b0; ramp_step = '0;
        pend_v = 1'b0; pend_c = 0; acc_m = 0; prev_obs = -1; saw_wrap = 1'b0;
        m_bin = '0; m_therm = '0; m_ovf = 1'b0;

        // Reset state
        step(); step();
        chk_out("reset", 8'h00, 17'h00000, 1'b0);
        chk("reset_binb", {24'd0, datainb}, 32'hFF);
        chk("reset_thermb", {15'd0, datathermb}, 32'h1FFFF);
        chk("reset_pdbout", {31'd0, pdb_out}, 32'd0);
        chk("reset_ready", {31'd0, code_ready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Wake aborted at WAKE cycle 5
        pdb = 1'b1;
        step();
        chk("wake_pdbout", {31'd0, pdb_out}, 32'd1);
        chk("wake_busy", {31'd0, busy}, 32'd1);
        chk("wake_ready", {31'd0, code_ready}, 32'd0);
        chk_out("wake_zero", 8'h00, 17'h00000, 1'b0);
        for (int i = 0; i < 4; i++) step();
        pdb = 1'b0;
        step();
        chk("abort_pdbout", {31'd0, pdb_out}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);

        // Full wake, then vector table back-to-back
        wake_up("wake1");
        chk("run_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i <= 9; i++) begin
            code_valid = (i < 9);
            code_in    = (i < 9) ? vtab[i].code : 13'h0;
            step();
            if (i >= 1) begin
                chk_out($sformatf("vec%0d", i - 1), vtab[i-1].bin, vtab[i-1].therm, vtab[i-1].ovf);
            end
        end
        code_valid = 1'b0;
        m_bin = 8'hFF; m_therm = 17'h1FFFF; m_ovf = 1'b0; pend_v = 1'b0;

        // Hold with no transfers, then randomized codes
        run_cycle(1'b0, 13'h0ABC, 1'b0, 8'd0);
        run_cycle(1'b0, 13'h0123, 1'b0, 8'd0);
        for (int i = 0; i < 150; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 13'($urandom), 1'b0, 8'd0);
        end
        run_cycle(1'b0, 13'h0, 1'b0, 8'd0);

        // Ramp: coarse steps toward the top, then step 16 across the wrap
        for (int i = 0; i < 19; i++) run_cycle(1'($urandom_range(0, 1)), 13'h0FFF, 1'b1, 8'd240);
        for (int i = 0; i < 6; i++)  run_cycle(1'b1, 13'h0FFF, 1'b1, 8'd16);
        chk("ramp_wrap_seen", {31'd0, saw_wrap}, 32'd1);
        run_cycle(1'b0, 13'h0, 1'b0, 8'd0);
        run_cycle(1'b0, 13'h0, 1'b0, 8'd0);
        // Accumulator retained across leaving test mode
        run_cycle(1'b0, 13'h0, 1'b1, 8'd16);
        run_cycle(1'b0, 13'h0, 1'b0, 8'd0);

        // Power-down from m=5 with a rejected code in the pdb-fall cycle
        run_cycle(1'b1, 13'h0533, 1'b0, 8'd0);
        run_cycle(1'b0, 13'h0, 1'b0, 8'd0);
        pdb = 1'b0; code_valid = 1'b1; code_in = 13'h0FFF;
        #1;
        chk("park_ready", {31'd0, code_ready}, 32'd0);
        step();
        code_valid = 1'b0;
        chk_out("park_k5", 8'h00, 17'h0001F, 1'b0);
        chk("park_busy", {31'd0, busy}, 32'd1);
        chk("park_pdbout", {31'd0, pdb_out}, 32'd1);
        for (int k = 4; k >= 0; k--) begin
            step();
            chk_out($sformatf("park_k%0d", k), 8'h00, 17'((1 << k) - 1), 1'b0);
        end
        step();
        chk("off_pdbout", {31'd0, pdb_out}, 32'd0);
        chk("off_busy", {31'd0, busy}, 32'd0);
        m_bin = '0; m_therm = '0; pend_v = 1'b0;

        // Reset in the middle of a PARK
        wake_up("wake2");
        run_cycle(1'b1, 13'h0A00, 1'b0, 8'd0);
        run_cycle(1'b0, 13'h0, 1'b0, 8'd0);
        pdb = 1'b0;
        step();
        chk_out("park2_k10", 8'h00, 17'h003FF, 1'b0);
        step();
        chk_out("park2_k9", 8'h00, 17'h001FF, 1'b0);
        rst = 1'b1;
        step();
        chk_out("midrst", 8'h00, 17'h00000, 1'b0);
        chk("midrst_binb", {24'd0, datainb}, 32'hFF);
        chk("midrst_thermb", {15'd0, datathermb}, 32'h1FFFF);
        chk("midrst_pdbout", {31'd0, pdb_out}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, code_ready}, 32'd0);
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
